// File: rtl/stk_pipe_dl_if.sv
`default_nettype none
// ============================================================================
// Module      : stk_pipe_dl_if
// Description : Bundles the retire-return handshake, the allocator snoop
//               inputs and the dealloc outputs of stk_pipe_dl. Signal names
//               keep the i_/o_ direction prefixes as seen from the engine.
//               The slave modport is the engine; the master modport is the
//               environment around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface stk_pipe_dl_if #(
  parameter int PTR_W = 8
) ();

  // Retire-side pointer return handshake.
  logic             i_rtn_vld;
  logic [PTR_W-1:0] i_rtn_ptr;
  logic             o_rtn_rdy;

  // Allocator snoop inputs.
  logic             i_ad_alloc;
  logic             i_al_init_busy;

  // Dealloc bus to the allocator, plus status.
  logic             o_dealloc_vld;
  logic [PTR_W-1:0] o_dealloc_ptr;
  logic             o_busy_r;
  logic             o_err_dup_r;

  modport slave (
    input  i_rtn_vld,
    input  i_rtn_ptr,
    output o_rtn_rdy,
    input  i_ad_alloc,
    input  i_al_init_busy,
    output o_dealloc_vld,
    output o_dealloc_ptr,
    output o_busy_r,
    output o_err_dup_r
  );

  modport master (
    output i_rtn_vld,
    output i_rtn_ptr,
    input  o_rtn_rdy,
    output i_ad_alloc,
    output i_al_init_busy,
    input  o_dealloc_vld,
    input  o_dealloc_ptr,
    input  o_busy_r,
    input  o_err_dup_r
  );

endinterface
`default_nettype wire

// File: rtl/stk_pipe_dl.sv
`default_nettype none
// ============================================================================
// Module      : stk_pipe_dl
// Description : Descriptor return (dealloc) engine. Buffers freed pointers
//               from the pipeline retire point in a small FIFO and hands them
//               back to the allocator one per cycle, preferring cycles where
//               the allocator admits an alloc so its collision bypass can
//               recycle the pointer directly.
//               Pointer layout is {bnk_id, line_id}, PTR_W bits in total.
//               Optional feature macro: STK_PIPE_DL_DUP_CHK_EN
//                 defined   -> duplicate-return detection, sticky o_err_dup_r
//                 undefined -> no compare logic, o_err_dup_r tied low
// Revision    : 1.0 - initial release
// ============================================================================
module stk_pipe_dl #(
  parameter int PTR_W  = 8,         // must match the interface PTR_W
  parameter int DEPTH  = 4,         // FIFO entries, power of two, >= 2
  parameter int HOLD_N = 3,         // max head wait for a collision, 0 = never hold
  parameter int HI_WM  = DEPTH - 1  // occupancy forcing unconditional emit
) (
  input  logic         clk,
  input  logic         arst,
  stk_pipe_dl_if.slave bus
);

  // --------------------------------------------------------------------------
  // Derived sizes and width-matched constants
  // --------------------------------------------------------------------------
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int AGE_W = (HOLD_N > 0) ? $clog2(HOLD_N + 1) : 1;

  localparam logic [CW-1:0]    C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]    C_HI_WM = CW'(HI_WM);
  localparam logic [AGE_W-1:0] C_HOLD  = AGE_W'(HOLD_N);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [PTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_empty;
  logic             w_full;
  logic             w_run;
  logic             w_push_acc;   // handshake completed on the return port
  logic             w_dup;        // accepted pointer already buffered
  logic             w_push;       // pointer actually written
  logic             w_emit;       // head goes to the allocator this cycle
  logic [PTR_W-1:0] w_head;

  assign w_empty    = (cnt_q == '0);
  assign w_full     = (cnt_q == C_DEPTH);
  assign w_run      = (state_q == ST_RUN);
  assign w_head     = mem_q[rd_ptr_q];

  // Ready depends on occupancy only, so there is no path from i_ad_alloc to
  // o_rtn_rdy; a full FIFO stalls even when its head leaves this cycle.
  assign w_push_acc = bus.i_rtn_vld & ~w_full;
  assign w_push     = w_push_acc & ~w_dup;

  // Emit on a same-cycle alloc (collision), on head timeout, or when the
  // buffer is close to full. Combinational from i_ad_alloc by design.
  assign w_emit = w_run & ~w_empty &
                  (bus.i_ad_alloc | (age_q >= C_HOLD) | (cnt_q >= C_HI_WM));

  // --------------------------------------------------------------------------
  // Duplicate-return detection
  // --------------------------------------------------------------------------
`ifdef STK_PIPE_DL_DUP_CHK_EN
  logic [DEPTH-1:0] w_slot_hit;

  // An entry is live when its distance from the read pointer is below the
  // occupancy. The head being popped this cycle is still live here, so the
  // same compare also covers the entry leaving the FIFO.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dup
    logic [AW-1:0] w_off;
    assign w_off          = AW'(gi) - rd_ptr_q;
    assign w_slot_hit[gi] = ({1'b0, w_off} < cnt_q) &&
                            (mem_q[gi] == bus.i_rtn_ptr);
  end

  assign w_dup = |w_slot_hit;

  // Sticky error: set by any accepted duplicate, cleared only by reset.
  always_comb begin
    err_d = err_q | (w_push_acc & w_dup);
  end
`else
  assign w_dup = 1'b0;

  // Feature not built: the error flag can never set.
  always_comb begin
    err_d = 1'b0;
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // FSM: leave INIT once the allocator finishes building its free list.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (!bus.i_al_init_busy) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally mod DEPTH.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (w_push) begin
      mem_d[wr_ptr_q] = bus.i_rtn_ptr;
    end
    wr_ptr_d = wr_ptr_q + AW'(w_push);
    rd_ptr_d = rd_ptr_q + AW'(w_emit);
    cnt_d    = cnt_q + CW'(w_push) - CW'(w_emit);
  end

  // Head age: counts RUN cycles the head waits, saturating at HOLD_N;
  // restarts for every new head and stays at zero while idle or in INIT.
  always_comb begin
    age_d = age_q;
    if (!w_run || w_empty || w_emit) begin
      age_d = '0;
    end else if (age_q < C_HOLD) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Busy status registered from next-state values so it tracks the
  // current INIT/occupancy state with no extra cycle of lag.
  always_comb begin
    busy_d = (state_d == ST_INIT) | (cnt_d != '0);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // All state clears asynchronously; buffered pointers are discarded.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_INIT;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      age_q    <= '0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.o_rtn_rdy     = ~w_full;
  assign bus.o_dealloc_vld = w_emit;
  assign bus.o_dealloc_ptr = w_emit ? w_head : '0;
  assign bus.o_busy_r      = busy_q;
  assign bus.o_err_dup_r   = err_q;

endmodule
`default_nettype wire
